// File: rtl/mayo_keygen_ctrl.sv
// mayo_keygen_ctrl
// AXI4-Lite register block and run sequencer for the MAYO key-generation core.
// A START write launches a run. The run ends on core_done, on a software ABORT,
// or on timeout. The block records the run length and sticky status bits, and
// drives a level interrupt.
module mayo_keygen_ctrl #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] TIMEOUT_DEFAULT    = 32'hFFFF_FFFF
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic                            core_abort,
  input  logic                            core_done,
  output logic                            irq
);

  // state    | meaning
  // S_IDLE   | no run in progress
  // S_LAUNCH | single cycle: core_start high, cycle counter cleared
  // S_RUN    | counting cycles until done, abort or timeout
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_LIMIT  = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  state_t      state, state_next;
  logic        aw_ready, b_valid, ar_ready, r_valid;
  logic [31:0] r_data;
  logic        irq_en, st_done, st_timeout, st_aborted, st_start_ign;
  logic [31:0] timeout_limit, run_count, cycle_count, count_inc, rd_mux;
  logic        wr_fire, rd_fire, ctrl_wr, status_wr, limit_wr, start_wr, abort_wr;
  logic [1:0]  wr_addr, rd_addr;
  logic [3:0]  w1c;
  logic        busy, timeout_hit;
  logic        start_ign, end_done, end_abort, end_timeout;
  logic        core_abort_q, irq_q;
  logic        unused_addr_bits;

  // The low address bits select a byte within a word. Every register is a full word, so those bits are not used.
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_addr   = S_AXI_AWADDR[3:2];
  assign rd_addr   = S_AXI_ARADDR[3:2];
  assign wr_fire   = aw_ready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire   = ar_ready & S_AXI_ARVALID;
  assign ctrl_wr   = wr_fire & (wr_addr == A_CTRL);
  assign status_wr = wr_fire & (wr_addr == A_STATUS);
  assign limit_wr  = wr_fire & (wr_addr == A_LIMIT);
  assign start_wr  = ctrl_wr & S_AXI_WDATA[0];
  assign abort_wr  = ctrl_wr & S_AXI_WDATA[1];
  assign w1c       = status_wr ? S_AXI_WDATA[4:1] : 4'b0000;

  assign busy        = (state != S_IDLE);
  assign count_inc   = (&run_count) ? run_count : run_count + 32'd1;
  assign timeout_hit = (count_inc >= timeout_limit);

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = aw_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = 2'b00;
  assign core_start    = (state == S_LAUNCH);
  assign core_abort    = core_abort_q;
  assign irq           = irq_q;

  // Write channel: raise a one-cycle ready once both AW and W are present and no response is pending.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
    end else begin
      aw_ready <= S_AXI_AWVALID & S_AXI_WVALID & ~b_valid & ~aw_ready;
      if (wr_fire)
        b_valid <= 1'b1;
      else if (S_AXI_BREADY)
        b_valid <= 1'b0;
    end
  end

  // Read data mux. It shows the register values from before any write accepted on the same edge.
  always_comb begin
    rd_mux = 32'd0;
    case (rd_addr)
      A_CTRL:   rd_mux = {29'd0, irq_en, 2'b00};
      A_STATUS: rd_mux = {27'd0, st_start_ign, st_aborted, st_timeout, st_done, busy};
      A_LIMIT:  rd_mux = timeout_limit;
      A_COUNT:  rd_mux = cycle_count;
      default:  rd_mux = 32'd0;
    endcase
  end

  // Read channel: a one-cycle ready, then registered data that is held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= 32'd0;
    end else begin
      ar_ready <= S_AXI_ARVALID & ~r_valid & ~ar_ready;
      if (rd_fire) begin
        r_valid <= 1'b1;
        r_data  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state and run-termination decode. When events coincide, core_done wins over ABORT, and ABORT wins over timeout.
  always_comb begin
    state_next  = state;
    start_ign   = 1'b0;
    end_done    = 1'b0;
    end_abort   = 1'b0;
    end_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_wr) begin
          if (st_done | st_timeout | st_aborted)
            start_ign = 1'b1;
          else
            state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start_ign  = start_wr;
        state_next = S_RUN;
      end
      S_RUN: begin
        start_ign = start_wr;
        if (core_done) begin
          end_done   = 1'b1;
          state_next = S_IDLE;
        end else if (abort_wr) begin
          end_abort  = 1'b1;
          state_next = S_IDLE;
        end else if (timeout_hit) begin
          end_timeout = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Run-length counter. The count latched at the end includes the terminating RUN cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      run_count   <= 32'd0;
      cycle_count <= 32'd0;
    end else begin
      if (state == S_LAUNCH)
        run_count <= 32'd0;
      else if (state == S_RUN)
        run_count <= count_inc;
      if (end_done | end_abort | end_timeout)
        cycle_count <= count_inc;
    end
  end

  // Software-visible registers. For a sticky bit, a hardware set in the same cycle wins over a write-1-to-clear.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_en        <= 1'b0;
      st_done       <= 1'b0;
      st_timeout    <= 1'b0;
      st_aborted    <= 1'b0;
      st_start_ign  <= 1'b0;
      timeout_limit <= TIMEOUT_DEFAULT;
    end else begin
      st_done      <= end_done    | (st_done      & ~w1c[0]);
      st_timeout   <= end_timeout | (st_timeout   & ~w1c[1]);
      st_aborted   <= end_abort   | (st_aborted   & ~w1c[2]);
      st_start_ign <= start_ign   | (st_start_ign & ~w1c[3]);
      if (ctrl_wr)
        irq_en <= S_AXI_WDATA[2];
      if (limit_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (S_AXI_WSTRB[b])
            timeout_limit[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  // Registered core_abort pulse and level interrupt.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      core_abort_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      core_abort_q <= end_abort | end_timeout;
      irq_q        <= irq_en & (st_done | st_timeout | st_aborted);
    end
  end

endmodule

// File: tb/tb_mayo_keygen_ctrl.sv
// Testbench for mayo_keygen_ctrl: a register vector table, hand-written run
// sequences, randomized runs checked against an event-time reference model,
// AXI back-pressure, and reset during a run.
module tb_mayo_keygen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        core_start, core_abort, core_done, irq;
  logic        model_done = 1'b0, force_done = 1'b0;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int done_delay = -1, cnt = 0, n_start = 0, n_abort = 0, start_cyc = 0;

  assign core_done = model_done | force_done;

  mayo_keygen_ctrl dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_start(core_start), .core_abort(core_abort), .core_done(core_done), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: pulses core_done done_delay cycles after core_start. An abort or a reset cancels it.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) cnt = 0;
    else if (core_abort) begin n_abort++; cnt = 0; end
    else if (cnt > 0) begin cnt--; if (cnt == 0) model_done = 1'b1; end
    if (core_start) begin n_start++; start_cyc = cyc; cnt = done_delay; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit with_done, output int fire_at);
    int k;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!awready && k < 20);
    check("wr_accept", 32'({awready, wready}), 32'd3);
    fire_at = cyc;
    force_done = with_done;
    @(negedge clk);
    force_done = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    k = 0;
    while (!bvalid && k < 20) begin @(negedge clk); k++; end
    check("wr_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int k;
    araddr = addr; arvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!arready && k < 20);
    check("rd_accept", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    k = 0;
    while (!rvalid && k < 20) begin @(negedge clk); k++; end
    check("rd_valid", 32'(rvalid), 32'd1);
    data = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    int f;
    axi_write(addr, data, 4'hF, 1'b0, f);
  endtask

  task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(addr, v);
    check(name, v, exp);
  endtask

  task automatic wait_idle(output logic [31:0] st);
    int k;
    k = 0;
    do begin axi_read(4'h4, st); k++; end while (st[0] && k < 80);
    check("run_ends", 32'(st[0]), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  raddr;
    logic [31:0] rexp;
    string       name;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] st, d0;
  int          fire, s0, a0, k, accepts;
  bit          early, stable;

  initial begin
    vecs[0] = '{4'h8, 32'h1234_5678, 4'b0001, 4'h8, 32'hFFFF_FF78, "limit_strb_b0"};
    vecs[1] = '{4'h8, 32'hAABB_CCDD, 4'b0110, 4'h8, 32'hFFBB_CC78, "limit_strb_b12"};
    vecs[2] = '{4'h8, 32'h0000_0064, 4'b1111, 4'h8, 32'h0000_0064, "limit_full"};
    vecs[3] = '{4'h0, 32'h0000_0004, 4'b1111, 4'h0, 32'h0000_0004, "ctrl_irq_en"};
    vecs[4] = '{4'h0, 32'h0000_0000, 4'b1111, 4'h0, 32'h0000_0000, "ctrl_clear"};
    vecs[5] = '{4'hC, 32'hDEAD_BEEF, 4'b1111, 4'hC, 32'h0000_0000, "count_ro"};
    vecs[6] = '{4'h4, 32'h0000_001F, 4'b1111, 4'h4, 32'h0000_0000, "status_w1c_idle"};
    vecs[7] = '{4'h0, 32'h0000_0004, 4'b1111, 4'h0, 32'h0000_0004, "ctrl_irq_en2"};

    // Reset state
    #12;
    check("reset_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
    check("reset_core_irq", 32'({core_start, core_abort, irq, bresp, rresp}), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_check("reset_status", 4'h4, 32'd0);
    rd_check("reset_limit", 4'h8, 32'hFFFF_FFFF);
    rd_check("reset_count", 4'hC, 32'd0);
    rd_check("reset_ctrl", 4'h0, 32'd0);

    // Register vector table
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 1'b0, fire);
      rd_check(vecs[i].name, vecs[i].raddr, vecs[i].rexp);
    end
    check("irq_no_status", 32'(irq), 32'd0);

    // Normal run finished by core_done after 10 cycles
    done_delay = 10; s0 = n_start;
    wr(4'h0, 32'h5);
    wait_idle(st);
    check("t1_start_once", 32'(n_start - s0), 32'd1);
    check("t1_status", st, 32'h2);
    rd_check("t1_count", 4'hC, 32'd10);
    check("t1_irq", 32'(irq), 32'd1);
    wr(4'h4, 32'h2);
    check("t1_irq_clear", 32'(irq), 32'd0);
    rd_check("t1_status_clear", 4'h4, 32'd0);

    // Timeout at limit 20
    done_delay = -1;
    wr(4'h8, 32'd20);
    a0 = n_abort;
    wr(4'h0, 32'h5);
    wait_idle(st);
    check("t2_abort_once", 32'(n_abort - a0), 32'd1);
    check("t2_status", st, 32'h4);
    rd_check("t2_count", 4'hC, 32'd20);
    wr(4'h4, 32'h4);

    // Software abort at RUN cycle 5, then START refused while ABORTED is still set
    wr(4'h8, 32'd100);
    a0 = n_abort;
    wr(4'h0, 32'h5);
    repeat (3) @(negedge clk);
    axi_write(4'h0, 32'h6, 4'hF, 1'b0, fire);
    check("t3_abort_cycle", 32'(fire - start_cyc), 32'd5);
    wait_idle(st);
    check("t3_abort_once", 32'(n_abort - a0), 32'd1);
    check("t3_status", st, 32'h8);
    rd_check("t3_count", 4'hC, 32'd5);
    s0 = n_start;
    wr(4'h0, 32'h5);
    repeat (3) @(negedge clk);
    rd_check("t3_start_ign", 4'h4, 32'h18);
    check("t3_no_start", 32'(n_start - s0), 32'd0);
    wr(4'h4, 32'h1E);
    rd_check("t3_cleared", 4'h4, 32'd0);

    // START while busy is ignored and the first run completes normally
    done_delay = 30; s0 = n_start;
    wr(4'h0, 32'h5);
    wr(4'h0, 32'h5);
    wait_idle(st);
    check("t4_status", st, 32'h12);
    rd_check("t4_count", 4'hC, 32'd30);
    check("t4_start_once", 32'(n_start - s0), 32'd1);
    wr(4'h4, 32'h1E);

    // core_done and ABORT in the same cycle: done wins, no core_abort
    done_delay = -1;
    wr(4'h0, 32'h5);
    repeat (4) @(negedge clk);
    a0 = n_abort;
    axi_write(4'h0, 32'h6, 4'hF, 1'b1, fire);
    wait_idle(st);
    check("t4_tie_status", st, 32'h2);
    rd_check("t4_tie_count", 4'hC, 32'(fire - start_cyc));
    check("t4_tie_no_abort", 32'(n_abort - a0), 32'd0);
    wr(4'h4, 32'h1E);

    // Randomized runs against an event-time model: the earliest of done/abort/timeout ends the run
    for (int i = 0; i < 12; i++) begin
      int  lim, dly, w, a, tlim, endc, inf;
      bit  ab, ie;
      logic [31:0] exp_st;
      inf  = 1 << 30;
      lim  = (i < 2) ? i : int'($urandom_range(2, 45));
      dly  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 50));
      ab   = 1'($urandom_range(0, 1));
      ie   = 1'($urandom_range(0, 1));
      w    = int'($urandom_range(0, 30));
      done_delay = dly;
      wr(4'h8, 32'(lim));
      s0 = n_start; a0 = n_abort;
      axi_write(4'h0, {29'd0, ie, 2'b01}, 4'hF, 1'b0, fire);
      a = inf;
      if (ab) begin
        repeat (w) @(negedge clk);
        axi_write(4'h0, {29'd0, ie, 2'b10}, 4'hF, 1'b0, fire);
        a = fire - start_cyc;
      end
      wait_idle(st);
      tlim = (lim < 1) ? 1 : lim;
      endc = tlim;
      if (a < endc) endc = a;
      if (dly > 0 && dly < endc) endc = dly;
      if (dly > 0 && dly == endc) exp_st = 32'h2;
      else if (a == endc)         exp_st = 32'h8;
      else                        exp_st = 32'h4;
      check("rnd_status", st, exp_st);
      rd_check("rnd_count", 4'hC, 32'(endc));
      check("rnd_start", 32'(n_start - s0), 32'd1);
      check("rnd_abort", 32'(n_abort - a0), (exp_st == 32'h2) ? 32'd0 : 32'd1);
      check("rnd_irq", 32'(irq), 32'(ie));
      wr(4'h4, 32'h1E);
      rd_check("rnd_clear", 4'h4, 32'd0);
    end

    // AXI write back-pressure: AW first, then W; BREADY low 7 cycles with a second write presented
    awaddr = 4'h8; wdata = 32'hCAFE_0001; wstrb = 4'hF; awvalid = 1'b1;
    early = 1'b0;
    repeat (3) begin @(negedge clk); if (awready) early = 1'b1; end
    check("aw_only_no_accept", 32'(early), 32'd0);
    wvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!awready && k < 20);
    check("stress_wr_accept", 32'(awready), 32'd1);
    accepts = 0; stable = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (awready) accepts++;
      if (!bvalid || bresp != 2'b00) stable = 1'b0;
    end
    check("no_second_accept", 32'(accepts), 32'd0);
    check("bvalid_held", 32'(stable), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rd_check("stress_wr_readback", 4'h8, 32'hCAFE_0001);

    // AXI read back-pressure: RREADY low 7 cycles with ARVALID still held
    araddr = 4'h8; arvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!arready && k < 20);
    @(negedge clk);
    d0 = rdata; accepts = 0; stable = rvalid;
    repeat (7) begin
      @(negedge clk);
      if (arready) accepts++;
      if (!rvalid || rdata !== d0) stable = 1'b0;
    end
    check("rd_no_second_accept", 32'(accepts), 32'd0);
    check("rvalid_rdata_held", 32'(stable), 32'd1);
    check("stress_rd_data", d0, 32'hCAFE_0001);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;

    // Simultaneous read and write of the same register returns the old value
    awaddr = 4'h8; wdata = 32'h0000_0055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!(awready && arready) && k < 20);
    check("sim_accept", 32'({awready, arready}), 32'd3);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("sim_old_value", rdata, 32'hCAFE_0001);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    rd_check("sim_new_value", 4'h8, 32'h0000_0055);

    // Reset in the middle of a run
    done_delay = -1;
    wr(4'h8, 32'd1000);
    wr(4'h0, 32'h5);
    repeat (5) @(negedge clk);
    a0 = n_abort;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
    check("midrun_rst_core_irq", 32'({core_start, core_abort, irq}), 32'd0);
    check("midrun_rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrun_no_abort", 32'(n_abort - a0), 32'd0);
    rd_check("midrun_limit_default", 4'h8, 32'hFFFF_FFFF);
    rd_check("midrun_status", 4'h4, 32'd0);
    rd_check("midrun_ctrl", 4'h0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
